// File: rtl/gate_truth_sweeper.sv
// Drives a two-input gate through 00,01,10,11, samples its output after a
// programmable settle time and reports the captured truth table.
module gate_truth_sweeper #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sense_y,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_out,
    output logic       match,
    output logic [3:0] mismatch
);

    // state  | meaning
    // IDLE   | inputs parked at 0, waiting for start
    // SETTLE | vector idx driven, counting settle cycles
    // SAMPLE | vector idx still driven, sense_y captured at the edge
    // DONE   | one-cycle result-valid pulse
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // A zero settle time is clamped to one cycle.
    localparam logic [7:0] SETTLE_LAST =
        (SETTLE_CYCLES <= 1) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic [3:0] cap;
    logic [3:0] cap_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        drv_a = 1'b0;
        drv_b = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            SETTLE, SAMPLE: begin
                {drv_a, drv_b} = idx;
                busy           = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture including the bit being sampled this cycle, so results can
    // load on the same edge that enters DONE.
    always_comb begin
        cap_nxt      = cap;
        cap_nxt[idx] = sense_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            cnt       <= 8'd0;
            cap       <= 4'd0;
            table_out <= 4'd0;
            match     <= 1'b0;
            mismatch  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= 2'd0;
                        cnt <= 8'd0;
                        cap <= 4'd0;
                    end
                end
                SETTLE: cnt <= cnt + 8'd1;
                SAMPLE: begin
                    cap <= cap_nxt;
                    if (idx == 2'd3) begin
                        table_out <= cap_nxt;
                        match     <= (cap_nxt == EXPECTED);
                        mismatch  <= cap_nxt ^ EXPECTED;
                    end else begin
                        idx <= idx + 2'd1;
                        cnt <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench: two sweeper instances (S=2 OR-expected, S=1 NAND-expected)
// driven by behavioural gate models, checked cycle by cycle.
module tb_gate_truth_sweeper;

    typedef struct {
        logic [3:0] tab;
        int         cyc;
    } sb_t;

    logic clk, rst, start;
    logic sel, mask;
    int   mdl;
    logic glitch;

    logic d0_a, d0_b, d0_busy, d0_done, d0_match, s0, st0;
    logic [3:0] d0_tab, d0_mis;
    logic d1_a, d1_b, d1_busy, d1_done, d1_match, s1, st1;
    logic [3:0] d1_tab, d1_mis;

    logic o_a, o_b, o_busy, o_done, o_match;
    logic [3:0] o_tab, o_mis;

    int   n_cmp, n_err;
    sb_t  exp_q[$];
    logic [3:0] last_tab [2];
    logic       last_match [2];
    logic [3:0] last_mis [2];

    gate_truth_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(4'b1110)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .sense_y(s0),
        .drv_a(d0_a), .drv_b(d0_b), .busy(d0_busy), .done(d0_done),
        .table_out(d0_tab), .match(d0_match), .mismatch(d0_mis));

    gate_truth_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(4'b0111)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .sense_y(s1),
        .drv_a(d1_a), .drv_b(d1_b), .busy(d1_busy), .done(d1_done),
        .table_out(d1_tab), .match(d1_match), .mismatch(d1_mis));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_y(input int m, input logic a, input logic b);
        case (m)
            0:       return a | b;
            1:       return a & b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [3:0] exp_table(input int m);
        logic [3:0] t;
        for (int k = 0; k < 4; k++) t[k] = model_y(m, k[1], k[0]);
        return t;
    endfunction

    always_comb begin
        st0 = start & ~sel;
        st1 = start & sel;
        s0  = model_y(mdl, d0_a, d0_b) & ~mask;
        s1  = model_y(mdl, d1_a, d1_b) & ~mask;
        o_a     = sel ? d1_a     : d0_a;
        o_b     = sel ? d1_b     : d0_b;
        o_busy  = sel ? d1_busy  : d0_busy;
        o_done  = sel ? d1_done  : d0_done;
        o_match = sel ? d1_match : d0_match;
        o_tab   = sel ? d1_tab   : d0_tab;
        o_mis   = sel ? d1_mis   : d0_mis;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int done_cyc);
        sb_t e;
        e.tab = exp_table(mdl);
        e.cyc = done_cyc;
        exp_q.push_back(e);
    endtask

    task automatic clear_last(input int d);
        last_tab[d]   = 4'd0;
        last_match[d] = 1'b0;
        last_mis[d]   = 4'd0;
    endtask

    // Called at the falling edge of cycle c; checks the selected DUT.
    task automatic step(input int c, input int s, input int start_cycles);
        int P, dc, base, r;
        bit active;
        logic [1:0] edrv;
        logic ebusy, edone;
        logic [3:0] expp;
        sb_t e;
        P      = 4 * (s + 1) + 2;
        dc     = 4 * (s + 1) + 1;
        base   = (c / P) * P;
        r      = c - base;
        active = (base < start_cycles);
        expp   = sel ? 4'b0111 : 4'b1110;
        edrv   = 2'b00;
        ebusy  = 1'b0;
        edone  = 1'b0;
        if (active && r == 0) push(base + dc);
        if (active && r >= 1 && r <= 4 * (s + 1)) begin
            edrv  = 2'((r - 1) / (s + 1));
            ebusy = 1'b1;
        end else if (active && r == dc) begin
            ebusy = 1'b1;
            edone = 1'b1;
        end
        mask = glitch && !(active && r >= 1 && r <= 4 * (s + 1) && (r % (s + 1)) == 0);
        chk("drv", {30'd0, o_a, o_b}, {30'd0, edrv});
        chk("busy", {31'd0, o_busy}, {31'd0, ebusy});
        chk("done", {31'd0, o_done}, {31'd0, edone});
        if (o_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", c, e.cyc);
                last_tab[sel]   = e.tab;
                last_match[sel] = (e.tab == expp);
                last_mis[sel]   = e.tab ^ expp;
            end
        end
        chk("table_out", {28'd0, o_tab}, {28'd0, last_tab[sel]});
        chk("match", {31'd0, o_match}, {31'd0, last_match[sel]});
        chk("mismatch", {28'd0, o_mis}, {28'd0, last_mis[sel]});
    endtask

    task automatic run(input int s, input int ncyc, input int start_cycles);
        @(negedge clk);
        start = 1'b1;
        mask  = 1'b0;
        @(posedge clk);
        push(4 * (s + 1) + 1);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c < start_cycles);
            step(c, s, start_cycles);
        end
        start = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sel    = 1'b0;
        mdl    = 0;
        glitch = 1'b0;
        mask   = 1'b0;
        clear_last(0);
        clear_last(1);
        repeat (2) @(negedge clk);
        chk("rst_d0_outs", {d0_a, d0_b, d0_busy, d0_done, d0_match, d0_tab, d0_mis}, 32'd0);
        chk("rst_d1_outs", {d1_a, d1_b, d1_busy, d1_done, d1_match, d1_tab, d1_mis}, 32'd0);
        rst = 1'b0;

        // OR gate, single start pulse
        mdl = 0;
        run(2, 15, 1);

        // AND gate, results must hold after done
        mdl = 1;
        run(2, 22, 1);

        // OR gate, start held high for 40 cycles
        mdl = 0;
        run(2, 45, 40);

        // Asynchronous reset in cycle 6 of a sweep
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            step(c, 2, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", {d0_a, d0_b, d0_busy, d0_done, d0_match, d0_tab, d0_mis}, 32'd0);
        clear_last(0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            chk("rst_no_done", {31'd0, d0_done}, 32'd0);
            chk("rst_idle_busy", {31'd0, d0_busy}, 32'd0);
            chk("rst_tab_clear", {28'd0, d0_tab}, 32'd0);
        end
        run(2, 15, 1);

        // OR gate with sense_y forced low outside SAMPLE cycles
        glitch = 1'b1;
        run(2, 15, 1);
        glitch = 1'b0;
        mask   = 1'b0;

        // S=1 instance, NAND gate
        sel = 1'b1;
        mdl = 2;
        run(1, 12, 1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
